// File: rtl/xor_cipher_ctrl_if.sv
// Pin-side bundle of the XOR cipher controller: config chain, run control and LFSR drive.
// master = pins/testbench side, slave = controller side.
interface xor_cipher_ctrl_if #(
    parameter int LFSR_W = 32
);
    logic              cfg_en;
    logic              cfg_i;
    logic              cfg_o;
    logic              start;
    logic              stop;
    logic              bit_valid;
    logic [LFSR_W-1:0] taps_o;
    logic [LFSR_W-1:0] seed_o;
    logic              lfsr_load;
    logic              lfsr_en;
    logic              key_sel;
    logic              busy;
    logic              frame_done;
    logic              cfg_err;

    modport master (
        output cfg_en, cfg_i, start, stop, bit_valid,
        input  cfg_o, taps_o, seed_o, lfsr_load, lfsr_en, key_sel, busy, frame_done, cfg_err
    );

    modport slave (
        input  cfg_en, cfg_i, start, stop, bit_valid,
        output cfg_o, taps_o, seed_o, lfsr_load, lfsr_en, key_sel, busy, frame_done, cfg_err
    );
endinterface

// File: rtl/xor_cipher_ctrl.sv
// XOR cipher controller: serial config chain, active taps/seed/key_sel, LFSR load/run/reseed sequencing.
// lfsr_en is combinational on bit_valid; all other outputs registered; no backpressure (bit_valid always accepted in RUN).
module xor_cipher_ctrl #(
    parameter int                LFSR_W       = 32,
    parameter logic [LFSR_W-1:0] DEFAULT_TAPS = LFSR_W'(32'h00000060),
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(32'h00000001),
    parameter int                FRAME_LEN    = 256,
    parameter int                CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    xor_cipher_ctrl_if.slave bus
);

    localparam int                  CHAIN_W    = 2 * LFSR_W + 1;
    localparam int                  SCNT_W     = 7;
    localparam logic [SCNT_W-1:0]   SCNT_MAX   = '1;
    localparam logic [SCNT_W-1:0]   CHAIN_CNT  = SCNT_W'(CHAIN_W);
    localparam logic [CNT_W-1:0]    FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CHAIN_W-1:0]  SHADOW_RST = {1'b0, DEFAULT_SEED, DEFAULT_TAPS};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        LOAD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [CHAIN_W-1:0]  shadow;
    logic [SCNT_W-1:0]   shift_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [LFSR_W-1:0]   taps_q;
    logic [LFSR_W-1:0]   seed_q;
    logic                key_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                cfg_err_q;

    logic                cfg_start;
    logic                shift_en;
    logic                cfg_exit;
    logic                cfg_ok;
    logic                bit_take;
    logic                frame_end;
    logic                lfsr_load_c;
    logic                lfsr_en_c;

    // Chain is only reachable from IDLE/CFG, so RUN can never disturb the shadow or cfg_o.
    assign cfg_start = (state == IDLE) && bus.cfg_en;
    assign shift_en  = ((state == IDLE) || (state == CFG)) && bus.cfg_en;
    assign cfg_exit  = (state == CFG) && !bus.cfg_en;
    assign cfg_ok    = (shift_cnt == CHAIN_CNT)
                    && (|shadow[LFSR_W-1:0])
                    && (|shadow[2*LFSR_W-1:LFSR_W]);
    assign bit_take  = (state == RUN) && bus.bit_valid && !bus.stop;
    assign frame_end = bit_take && (bit_cnt == FRAME_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.cfg_en) begin
                    state_nxt = CFG;
                end else if (bus.start) begin
                    state_nxt = LOAD;
                end
            end
            CFG: begin
                if (!bus.cfg_en) begin
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (frame_end) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        lfsr_load_c = 1'b0;
        lfsr_en_c   = 1'b0;
        case (state)
            LOAD:    lfsr_load_c = 1'b1;
            RUN:     lfsr_en_c   = bit_take;
            default: begin
                lfsr_load_c = 1'b0;
                lfsr_en_c   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= SHADOW_RST;
            shift_cnt <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (shift_en) begin
                shadow <= {bus.cfg_i, shadow[CHAIN_W-1:1]};
            end
            if (cfg_start) begin
                shift_cnt <= SCNT_W'(1);
            end else if (shift_en && (shift_cnt != SCNT_MAX)) begin
                shift_cnt <= shift_cnt + SCNT_W'(1);
            end
            if (cfg_start) begin
                cfg_err_q <= 1'b0;
            end else if (cfg_exit && !cfg_ok) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    // A rejected chain leaves the active set untouched; only a full, non-zero chain is applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps_q <= DEFAULT_TAPS;
            seed_q <= DEFAULT_SEED;
            key_q  <= 1'b0;
        end else if (cfg_exit && cfg_ok) begin
            taps_q <= shadow[LFSR_W-1:0];
            seed_q <= shadow[2*LFSR_W-1:LFSR_W];
            key_q  <= shadow[CHAIN_W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if (bit_take) begin
                bit_cnt <= frame_end ? '0 : bit_cnt + CNT_W'(1);
            end
            frame_done_q <= frame_end;
        end
    end

    assign bus.cfg_o      = shadow[0];
    assign bus.taps_o     = taps_q;
    assign bus.seed_o     = seed_q;
    assign bus.key_sel    = key_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.lfsr_load  = lfsr_load_c;
    assign bus.lfsr_en    = lfsr_en_c;

    a_load_en_excl: assert property (@(posedge clk) disable iff (rst)
        !(lfsr_load_c && lfsr_en_c));
    a_done_reseeds: assert property (@(posedge clk) disable iff (rst)
        frame_done_q |-> (state == LOAD));

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Bench for xor_cipher_ctrl: table of config chains plus scoreboarded run/stop/reset sequences.
module tb_xor_cipher_ctrl;

    localparam int LFSR_W    = 32;
    localparam int FRAME_LEN = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    xor_cipher_ctrl_if #(.LFSR_W(LFSR_W)) bus ();

    xor_cipher_ctrl #(
        .LFSR_W       (LFSR_W),
        .DEFAULT_TAPS (32'h00000060),
        .DEFAULT_SEED (32'h00000001),
        .FRAME_LEN    (FRAME_LEN),
        .CNT_W        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] taps;
        logic [31:0] seed;
        logic        key;
        int          nbits;
        logic [31:0] exp_taps;
        logic [31:0] exp_seed;
        logic        exp_key;
        logic        exp_err;
    } cfg_vec_t;

    typedef struct {
        logic load;
        logic en;
        logic fd;
        logic busy;
    } run_exp_t;

    cfg_vec_t   vecs [7];
    logic       q_cfgo [$];
    run_exp_t   q_run [$];
    logic [64:0] m_shadow;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_cfg(input cfg_vec_t v, input int idx);
        logic [64:0] word;
        logic        b;
        word = {v.key, v.seed, v.taps};
        @(negedge clk);
        check($sformatf("v%0d cfg_o_pre", idx), 64'(bus.cfg_o), 64'(m_shadow[0]));
        for (int i = 0; i < v.nbits; i++) begin
            if (i > 0) @(negedge clk);
            b = (i < 65) ? word[i] : 1'b0;
            bus.cfg_en = 1'b1;
            bus.cfg_i  = b;
            m_shadow   = {b, m_shadow[64:1]};
            q_cfgo.push_back(m_shadow[0]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d cfg_o[%0d]", idx, i), 64'(bus.cfg_o), 64'(q_cfgo.pop_front()));
            if (i == 0) begin
                check($sformatf("v%0d err_clr", idx), 64'(bus.cfg_err), 64'(0));
                check($sformatf("v%0d busy_cfg", idx), 64'(bus.busy), 64'(1));
            end
        end
        @(negedge clk);
        bus.cfg_en = 1'b0;
        bus.cfg_i  = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("v%0d taps", idx), 64'(bus.taps_o), 64'(v.exp_taps));
        check($sformatf("v%0d seed", idx), 64'(bus.seed_o), 64'(v.exp_seed));
        check($sformatf("v%0d key", idx), 64'(bus.key_sel), 64'(v.exp_key));
        check($sformatf("v%0d err", idx), 64'(bus.cfg_err), 64'(v.exp_err));
        check($sformatf("v%0d busy_idle", idx), 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        run_exp_t e;
        run_exp_t got;
        int       ph;

        vecs[0] = '{32'h80200003, 32'hACE1ACE1, 1'b1, 65, 32'h80200003, 32'hACE1ACE1, 1'b1, 1'b0};
        vecs[1] = '{32'h12345678, 32'h0BADF00D, 1'b0, 64, 32'h80200003, 32'hACE1ACE1, 1'b1, 1'b1};
        vecs[2] = '{32'h80200003, 32'h00000000, 1'b0, 65, 32'h80200003, 32'hACE1ACE1, 1'b1, 1'b1};
        vecs[3] = '{32'h00000000, 32'h00000001, 1'b0, 65, 32'h80200003, 32'hACE1ACE1, 1'b1, 1'b1};
        vecs[4] = '{32'h000000A3, 32'h5EED0001, 1'b0, 65, 32'h000000A3, 32'h5EED0001, 1'b0, 1'b0};
        vecs[5] = '{32'h11111111, 32'h22222222, 1'b1, 70, 32'h000000A3, 32'h5EED0001, 1'b0, 1'b1};
        vecs[6] = '{32'hDEADBEEF, 32'h00C0FFEE, 1'b0, 65, 32'hDEADBEEF, 32'h00C0FFEE, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.cfg_en    = 1'b0;
        bus.cfg_i     = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.bit_valid = 1'b0;
        m_shadow      = {1'b0, 32'h00000001, 32'h00000060};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst taps", 64'(bus.taps_o), 64'h60);
        check("rst seed", 64'(bus.seed_o), 64'h1);
        check("rst key", 64'(bus.key_sel), 64'(0));
        check("rst busy", 64'(bus.busy), 64'(0));
        check("rst err", 64'(bus.cfg_err), 64'(0));
        check("rst cfg_o", 64'(bus.cfg_o), 64'(0));
        check("rst load", 64'(bus.lfsr_load), 64'(0));
        check("rst en", 64'(bus.lfsr_en), 64'(0));
        check("rst fd", 64'(bus.frame_done), 64'(0));

        for (int i = 0; i < 7; i++) do_cfg(vecs[i], i);

        // Reset in the middle of a shift discards the partial chain.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.cfg_en = 1'b1;
            bus.cfg_i  = 1'b1;
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst taps", 64'(bus.taps_o), 64'h60);
        check("mid rst seed", 64'(bus.seed_o), 64'h1);
        check("mid rst cfg_o", 64'(bus.cfg_o), 64'(0));
        check("mid rst busy", 64'(bus.busy), 64'(0));
        check("mid rst key", 64'(bus.key_sel), 64'(0));
        bus.cfg_en = 1'b0;
        bus.cfg_i  = 1'b0;
        m_shadow   = {1'b0, 32'h00000001, 32'h00000060};
        @(negedge clk);
        rst = 1'b0;

        // Run with FRAME_LEN=4: load, 4 enables, reseed with frame_done; cfg pulse mid-run, stop+bit_valid.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.start     = (k == 0);
            bus.bit_valid = 1'b1;
            bus.stop      = (k == 17);
            bus.cfg_en    = (k == 8);
            bus.cfg_i     = 1'b1;
            e = '{1'b0, 1'b0, 1'b0, 1'b0};
            if (k >= 1 && k <= 17) begin
                ph     = (k - 1) % 5;
                e.load = (ph == 0);
                e.en   = (ph != 0) && (k != 17);
                e.fd   = (ph == 0) && (k >= 6);
                e.busy = 1'b1;
            end
            q_run.push_back(e);
            #1;
            got = q_run.pop_front();
            check($sformatf("run%0d load", k), 64'(bus.lfsr_load), 64'(got.load));
            check($sformatf("run%0d en", k), 64'(bus.lfsr_en), 64'(got.en));
            check($sformatf("run%0d fd", k), 64'(bus.frame_done), 64'(got.fd));
            check($sformatf("run%0d busy", k), 64'(bus.busy), 64'(got.busy));
            check($sformatf("run%0d cfg_o", k), 64'(bus.cfg_o), 64'(m_shadow[0]));
        end
        @(negedge clk);
        bus.bit_valid = 1'b0;
        bus.cfg_en    = 1'b0;
        bus.cfg_i     = 1'b0;
        #1;
        check("post run taps", 64'(bus.taps_o), 64'h60);
        check("post run err", 64'(bus.cfg_err), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xor_cipher_ctrl.md
Name: xor_cipher_ctrl

Overview:
- Controller for the XOR cipher datapath.
- Owns the serial configuration chain (cfg_en/cfg_i/cfg_o) and holds the active LFSR taps, seed and key-source select.
- Sequences the Galois LFSR keystream generator through load (seed), run (advance per data bit) and periodic frame reseed.
- Sits between the top-level pins and the LFSR/cipher core.

Parameters:
- LFSR_W, 32, width of taps and seed.
- DEFAULT_TAPS, 32'h00000060, taps value after reset.
- DEFAULT_SEED, 32'h00000001, seed value after reset.
- FRAME_LEN, 256, data bits per frame before automatic reseed; legal range 1..2^CNT_W.
- CNT_W, 16, width of the frame bit counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- cfg_en  in  1  config chain shift enable
- cfg_i  in  1  config serial data in
- cfg_o  out  1  config serial data out (chain LSB, registered)
- start  in  1  one-cycle request to begin keystream generation
- stop  in  1  one-cycle request to halt and return to idle
- bit_valid  in  1  a data bit is consumed this cycle
- taps_o  out  LFSR_W  active taps to LFSR
- seed_o  out  LFSR_W  active seed to LFSR
- lfsr_load  out  1  load seed into LFSR this cycle
- lfsr_en  out  1  advance LFSR this cycle
- key_sel  out  1  0 = internal LFSR key, 1 = external_k
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  sticky config error flag

Behaviour:
- Reset (async, active-high):
  - state=IDLE; taps_o=DEFAULT_TAPS; seed_o=DEFAULT_SEED; key_sel=0.
  - shadow chain = {1'b0, DEFAULT_SEED, DEFAULT_TAPS} (2*LFSR_W+1 bits).
  - shift count=0, bit count=0.
  - cfg_o=shadow[0]; lfsr_load=0, lfsr_en=0, frame_done=0, cfg_err=0, busy=0.
- Chain format: shadow[LFSR_W-1:0]=taps, shadow[2*LFSR_W-1:LFSR_W]=seed, shadow[2*LFSR_W]=key_sel.
- Shift rule: each shifting cycle, shadow <= {cfg_i, shadow[top:1]}; cfg_o follows the new shadow[0]. The first bit shifted in ends up at bit 0 after a full load.
- FSM states: IDLE, CFG, LOAD, RUN.
- IDLE:
  - cfg_en=1 -> CFG. The shift happens this cycle, shift count=1, and cfg_err clears.
  - else start=1 -> LOAD.
  - cfg_en has priority over start.
- CFG:
  - While cfg_en=1: shift, and the shift count increments (saturating at 2^7-1).
  - On the first cycle with cfg_en=0: no shift; go to IDLE. Apply check in the same cycle:
    - count == 2*LFSR_W+1, shadow taps != 0 and shadow seed != 0 -> copy shadow into taps_o/seed_o/key_sel on the next edge.
    - otherwise -> active registers unchanged and cfg_err=1.
  - start in CFG is ignored.
- LOAD: lfsr_load=1 for exactly one cycle; bit count=0 -> RUN.
- RUN:
  - lfsr_en = bit_valid & ~stop (combinational, same cycle).
  - Each bit_valid increments the bit count.
  - bit_valid with count == FRAME_LEN-1 -> frame_done=1 on the next cycle, state -> LOAD (reseed), count=0.
  - stop=1 -> IDLE; stop wins over a simultaneous bit_valid (no advance, no frame_done).
  - cfg_en and start in RUN/LOAD are ignored: no shift, and cfg_o holds.
- key_sel=1: the sequencing is identical. Only the key source changes downstream.
- Config taps/seed are never modified while in RUN. Reconfiguration requires stop first.
- busy is registered with the state.
- Reset mid-shift or mid-run returns everything to reset values immediately. A partially shifted chain is discarded.

Test Plan:
1. Reset, then read outputs -> taps_o=0x00000060, seed_o=0x00000001, key_sel=0, busy=0, cfg_err=0; cfg_o=0 (bit 0 of 0x60).
2. Shift 65 bits encoding taps=0x80200003, seed=0xACE1ACE1, key_sel=1, then drop cfg_en -> outputs take these values one cycle later; cfg_err=0. cfg_o during the shift reproduces the old chain LSB-first (0x60 pattern first).
3. Shift only 64 bits, then drop cfg_en -> cfg_err=1, outputs keep their previous values. Start a new 65-bit shift -> cfg_err clears on the first shift cycle.
4. Shift 65 bits with seed=0 -> cfg_err=1 and seed_o unchanged.
5. FRAME_LEN=4: pulse start, drive bit_valid continuously -> one lfsr_load cycle, then 4 lfsr_en cycles, frame_done pulses, lfsr_load again. The pattern repeats every 5 cycles.
6. In RUN, assert stop and bit_valid together -> lfsr_en=0 that cycle, state returns to IDLE with busy=0. A cfg_en pulse asserted during RUN is ignored (taps_o unchanged, cfg_o stable).
